// File: rtl/editor_hora_fecha_if.sv
// Bus from the push-button editor to the RTC write stage: the BCD values,
// the clock/timer select and the write request/acknowledge pair.
interface editor_hora_fecha_if;
    logic [7:0] clk_seg;
    logic [7:0] clk_min;
    logic [7:0] clk_hora;
    logic [7:0] tim_seg;
    logic [7:0] tim_min;
    logic [7:0] tim_hora;
    logic [7:0] dia;
    logic [7:0] mes;
    logic [7:0] ano;
    logic       ct;
    logic       esc_req;
    logic       listo;

    modport master (
        output clk_seg, clk_min, clk_hora, tim_seg, tim_min, tim_hora,
        output dia, mes, ano, ct, esc_req,
        input  listo
    );

    modport slave (
        input  clk_seg, clk_min, clk_hora, tim_seg, tim_min, tim_hora,
        input  dia, mes, ano, ct, esc_req,
        output listo
    );
endinterface

// File: rtl/editor_hora_fecha.sv
// Push-button editor: turns button edges into BCD clock/timer/date values and
// issues a write request that is held until the write stage answers or times out.
//
// state    | meaning
// EDITAR   | buttons edit the group chosen by modo; guardar starts a write
// SOLICITA | raise esc_req, clear the timeout counter
// ESPERA   | hold esc_req until listo or timeout; values frozen
module editor_hora_fecha #(
    parameter int T_ESPERA = 1000,
    parameter int ANCHO_T  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    input  logic       btn_izq,
    input  logic       btn_der,
    input  logic       btn_guardar,
    input  logic [1:0] modo,
    output logic [1:0] campo,
    output logic       error,
    editor_hora_fecha_if.master bus
);
    typedef enum logic [1:0] {EDITAR, SOLICITA, ESPERA} estado_t;

    estado_t      estado, estado_n;
    logic [4:0]   btn_prev;
    logic [4:0]   accion;
    logic [1:0]   modo_prev;
    logic         modo_cambio;
    logic [ANCHO_T-1:0] cnt, cnt_n;
    logic [1:0]   campo_n;
    logic         ct_n, req_n, err_n;
    logic [7:0]   cs, cm, ch, ts, tm, th, di, me, an;
    logic [7:0]   cs_n, cm_n, ch_n, ts_n, tm_n, th_n, di_n, me_n, an_n;
    logic         sube, editar;

    // BCD step inside [lo, hi] with wrap at both ends
    function automatic logic [7:0] paso(input logic [7:0] v, input logic [7:0] lo,
                                        input logic [7:0] hi, input logic up);
        if (up) begin
            if (v >= hi)               paso = lo;
            else if (v[3:0] == 4'd9)   paso = {v[7:4] + 4'd1, 4'd0};
            else                       paso = {v[7:4], v[3:0] + 4'd1};
        end else begin
            if (v <= lo)               paso = hi;
            else if (v[3:0] == 4'd0)   paso = {v[7:4] - 4'd1, 4'd9};
            else                       paso = {v[7:4], v[3:0] - 4'd1};
        end
    endfunction

    // A BCD year is divisible by 4 depending only on units digit and tens parity
    function automatic logic [7:0] dias_max(input logic [7:0] m, input logic [3:0] a_uni,
                                            input logic a_dec_impar);
        logic bisiesto;
        bisiesto = ((a_uni == 4'd0 || a_uni == 4'd4 || a_uni == 4'd8) && !a_dec_impar) ||
                   ((a_uni == 4'd2 || a_uni == 4'd6) && a_dec_impar);
        case (m)
            8'h04, 8'h06, 8'h09, 8'h11: dias_max = 8'h30;
            8'h02:                      dias_max = bisiesto ? 8'h29 : 8'h28;
            default:                    dias_max = 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] recorta(input logic [7:0] d, input logic [7:0] mx);
        recorta = (d > mx) ? mx : d;
    endfunction

    assign accion      = {btn_guardar, btn_der, btn_izq, btn_abajo, btn_arriba} & ~btn_prev;
    assign modo_cambio = (modo != modo_prev);
    assign sube        = accion[0];
    assign editar      = (estado == EDITAR) && !modo_cambio;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado    <= EDITAR;
            btn_prev  <= '0;
            modo_prev <= 2'b00;
            cnt       <= '0;
            campo     <= 2'd0;
            bus.ct    <= 1'b0;
            bus.esc_req <= 1'b0;
            error     <= 1'b0;
            cs <= 8'h00; cm <= 8'h00; ch <= 8'h00;
            ts <= 8'h00; tm <= 8'h00; th <= 8'h00;
            di <= 8'h01; me <= 8'h01; an <= 8'h00;
        end else begin
            estado    <= estado_n;
            btn_prev  <= {btn_guardar, btn_der, btn_izq, btn_abajo, btn_arriba};
            modo_prev <= modo;
            cnt       <= cnt_n;
            campo     <= campo_n;
            bus.ct    <= ct_n;
            bus.esc_req <= req_n;
            error     <= err_n;
            cs <= cs_n; cm <= cm_n; ch <= ch_n;
            ts <= ts_n; tm <= tm_n; th <= th_n;
            di <= di_n; me <= me_n; an <= an_n;
        end
    end

    always_comb begin
        estado_n = estado;
        cnt_n    = cnt;
        campo_n  = campo;
        ct_n     = bus.ct;
        req_n    = bus.esc_req;
        err_n    = error;
        cs_n = cs; cm_n = cm; ch_n = ch;
        ts_n = ts; tm_n = tm; th_n = th;
        di_n = di; me_n = me; an_n = an;

        case (estado)
            EDITAR: begin
                if (editar) begin
                    // Field edit uses the cursor as it was before any move this cycle
                    if (accion[0] ^ accion[1]) begin
                        case (modo)
                            2'b00: case (campo)
                                2'd0:    cs_n = paso(cs, 8'h00, 8'h59, sube);
                                2'd1:    cm_n = paso(cm, 8'h00, 8'h59, sube);
                                2'd2:    ch_n = paso(ch, 8'h00, 8'h23, sube);
                                default: ;
                            endcase
                            2'b10: case (campo)
                                2'd0:    ts_n = paso(ts, 8'h00, 8'h59, sube);
                                2'd1:    tm_n = paso(tm, 8'h00, 8'h59, sube);
                                2'd2:    th_n = paso(th, 8'h00, 8'h23, sube);
                                default: ;
                            endcase
                            2'b01: case (campo)
                                2'd0: di_n = paso(di, 8'h01, dias_max(me, an[3:0], an[4]), sube);
                                2'd1: begin
                                    me_n = paso(me, 8'h01, 8'h12, sube);
                                    di_n = recorta(di, dias_max(me_n, an[3:0], an[4]));
                                end
                                2'd2: begin
                                    an_n = paso(an, 8'h00, 8'h99, sube);
                                    di_n = recorta(di, dias_max(me, an_n[3:0], an_n[4]));
                                end
                                default: ;
                            endcase
                            default: ;
                        endcase
                    end
                    if (accion[2] && !accion[3])
                        campo_n = (campo == 2'd0) ? 2'd2 : campo - 2'd1;
                    else if (accion[3] && !accion[2])
                        campo_n = (campo >= 2'd2) ? 2'd0 : campo + 2'd1;
                    if (accion[4] && modo != 2'b11) begin
                        estado_n = SOLICITA;
                        ct_n     = (modo == 2'b10);
                        err_n    = 1'b0;
                    end
                end
            end
            SOLICITA: begin
                req_n    = 1'b1;
                cnt_n    = '0;
                estado_n = ESPERA;
            end
            ESPERA: begin
                if (bus.listo) begin
                    req_n    = 1'b0;
                    estado_n = EDITAR;
                end else if (cnt == ANCHO_T'(T_ESPERA - 1)) begin
                    req_n    = 1'b0;
                    err_n    = 1'b1;
                    estado_n = EDITAR;
                end else begin
                    cnt_n = cnt + ANCHO_T'(1);
                end
            end
            default: estado_n = EDITAR;
        endcase

        if (modo_cambio) campo_n = 2'd0;
    end

    assign bus.clk_seg  = cs;
    assign bus.clk_min  = cm;
    assign bus.clk_hora = ch;
    assign bus.tim_seg  = ts;
    assign bus.tim_min  = tm;
    assign bus.tim_hora = th;
    assign bus.dia      = di;
    assign bus.mes      = me;
    assign bus.ano      = an;
endmodule

// File: tb/tb_editor_hora_fecha.sv
// Bench for editor_hora_fecha: directed and random button sequences checked
// against an integer model of clock, timer and calendar rules.
module tb_editor_hora_fecha;
    logic       clk = 1'b0;
    logic       reset;
    logic       btn_arriba, btn_abajo, btn_izq, btn_der, btn_guardar;
    logic [1:0] modo;
    logic [1:0] campo;
    logic       error;
    int         checks = 0;
    int         errors = 0;

    editor_hora_fecha_if bus ();

    editor_hora_fecha #(.T_ESPERA(8), .ANCHO_T(4)) dut (
        .clk(clk), .reset(reset),
        .btn_arriba(btn_arriba), .btn_abajo(btn_abajo),
        .btn_izq(btn_izq), .btn_der(btn_der), .btn_guardar(btn_guardar),
        .modo(modo), .campo(campo), .error(error), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model kept as plain integers
    int cs, cm, ch, ts, tm, th, d, mo, y, m_campo, m_modo;
    int m_ct, m_req, m_err;

    function automatic logic [7:0] bcd(input int n);
        bcd = {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic int dmax(input int mes, input int ano);
        int tabla [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mes == 2 && ano % 4 == 0) dmax = 29;
        else dmax = tabla[mes - 1];
    endfunction

    function automatic int envolver(input int v, input int n);
        envolver = (v + n) % n;
    endfunction

    task automatic model_reset();
        cs = 0; cm = 0; ch = 0; ts = 0; tm = 0; th = 0;
        d = 1; mo = 1; y = 0; m_campo = 0;
        m_ct = 0; m_req = 0; m_err = 0;
    endtask

    task automatic model_press(input bit up, input bit dn, input bit l, input bit r);
        int dl;
        if (up != dn && m_modo != 3) begin
            dl = up ? 1 : -1;
            if (m_modo == 0) begin
                if (m_campo == 0) cs = envolver(cs + dl, 60);
                else if (m_campo == 1) cm = envolver(cm + dl, 60);
                else ch = envolver(ch + dl, 24);
            end else if (m_modo == 2) begin
                if (m_campo == 0) ts = envolver(ts + dl, 60);
                else if (m_campo == 1) tm = envolver(tm + dl, 60);
                else th = envolver(th + dl, 24);
            end else begin
                if (m_campo == 0) d = envolver(d - 1 + dl, dmax(mo, y)) + 1;
                else if (m_campo == 1) mo = envolver(mo - 1 + dl, 12) + 1;
                else y = envolver(y + dl, 100);
                if (d > dmax(mo, y)) d = dmax(mo, y);
            end
        end
        if (l && !r) m_campo = (m_campo + 2) % 3;
        else if (r && !l) m_campo = (m_campo + 1) % 3;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".clk_seg"},  bus.clk_seg,  bcd(cs));
        chk({tag, ".clk_min"},  bus.clk_min,  bcd(cm));
        chk({tag, ".clk_hora"}, bus.clk_hora, bcd(ch));
        chk({tag, ".tim_seg"},  bus.tim_seg,  bcd(ts));
        chk({tag, ".tim_min"},  bus.tim_min,  bcd(tm));
        chk({tag, ".tim_hora"}, bus.tim_hora, bcd(th));
        chk({tag, ".dia"},      bus.dia,      bcd(d));
        chk({tag, ".mes"},      bus.mes,      bcd(mo));
        chk({tag, ".ano"},      bus.ano,      bcd(y));
        chk({tag, ".campo"},    {6'd0, campo}, 8'(m_campo));
        chk({tag, ".ct"},       {7'd0, bus.ct}, 8'(m_ct));
        chk({tag, ".esc_req"},  {7'd0, bus.esc_req}, 8'(m_req));
        chk({tag, ".error"},    {7'd0, error}, 8'(m_err));
    endtask

    // One-cycle press of any combination of arriba/abajo/izq/der
    task automatic press(input string tag, input bit up, input bit dn, input bit l, input bit r);
        @(negedge clk);
        btn_arriba = up; btn_abajo = dn; btn_izq = l; btn_der = r;
        @(negedge clk);
        btn_arriba = 0; btn_abajo = 0; btn_izq = 0; btn_der = 0;
        model_press(up, dn, l, r);
        check_all(tag);
    endtask

    task automatic set_modo(input int m);
        if (m != m_modo) begin
            @(negedge clk);
            modo = 2'(m);
            m_modo = m;
            @(negedge clk);
            m_campo = 0;
            check_all("modo");
        end
    endtask

    task automatic guardar();
        @(negedge clk);
        btn_guardar = 1;
        @(negedge clk);
        btn_guardar = 0;
    endtask

    initial begin
        int n;
        reset = 1; btn_arriba = 0; btn_abajo = 0; btn_izq = 0; btn_der = 0;
        btn_guardar = 0; modo = 2'b00; bus.listo = 0; m_modo = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 0;

        // Seconds: full wrap up, then borrow through zero
        for (int i = 0; i < 61; i++) press("seg_up", 1, 0, 0, 0);
        press("seg_dn", 0, 1, 0, 0);
        press("seg_dn0", 0, 1, 0, 0);
        chk("seg_59", bus.clk_seg, 8'h59);

        press("der1", 0, 0, 0, 1);
        press("der2", 0, 0, 0, 1);
        press("hora_dn", 0, 1, 0, 0);
        chk("hora_23", bus.clk_hora, 8'h23);
        press("der_wrap", 0, 0, 0, 1);
        press("izq_der", 0, 0, 1, 1);
        press("up_dn", 1, 1, 0, 0);

        // Calendar rules
        set_modo(1);
        press("mes_cur", 0, 0, 0, 1);
        press("mes_02", 1, 0, 0, 0);
        press("ano_cur", 0, 0, 0, 1);
        press("ano_01", 1, 0, 0, 0);
        press("dia_cur", 0, 0, 0, 1);
        press("dia_28", 0, 1, 0, 0);
        chk("dia_max28", bus.dia, 8'h28);
        press("dia_wrap", 1, 0, 0, 0);
        chk("dia_01", bus.dia, 8'h01);
        press("ano_cur2", 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) press("ano_04", 1, 0, 0, 0);
        press("dia_cur2", 0, 0, 0, 1);
        press("dia_29", 0, 1, 0, 0);
        chk("dia_leap", bus.dia, 8'h29);
        press("ano_cur3", 0, 0, 1, 0);
        press("ano_05", 1, 0, 0, 0);
        chk("dia_clamp28", bus.dia, 8'h28);
        press("mes_cur2", 0, 0, 1, 0);
        press("mes_03", 1, 0, 0, 0);
        press("dia_cur3", 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) press("dia_31", 1, 0, 0, 0);
        press("mes_cur3", 0, 0, 0, 1);
        press("mes_04", 1, 0, 0, 0);
        chk("dia_clamp30", bus.dia, 8'h30);

        // Random editing across groups
        for (int i = 0; i < 150; i++) begin
            logic [3:0] msk;
            if ($urandom_range(0, 7) == 0) set_modo(int'($urandom_range(0, 3)));
            msk = 4'($urandom_range(1, 15));
            press("rnd", msk[0], msk[1], msk[2], msk[3]);
        end

        // guardar with no-edit mode is ignored
        set_modo(3);
        guardar();
        repeat (2) @(negedge clk);
        chk("modo3_req", {7'd0, bus.esc_req}, 8'd0);

        // Timer write with listo
        set_modo(2);
        guardar();
        chk("tim_ct", {7'd0, bus.ct}, 8'd1);
        chk("tim_req0", {7'd0, bus.esc_req}, 8'd0);
        @(negedge clk);
        chk("tim_req1", {7'd0, bus.esc_req}, 8'd1);
        btn_arriba = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("tim_hold", {7'd0, bus.esc_req}, 8'd1);
            chk("tim_frozen", bus.tim_seg, bcd(ts));
        end
        bus.listo = 1;
        @(negedge clk);
        bus.listo = 0;
        chk("listo_req", {7'd0, bus.esc_req}, 8'd0);
        chk("listo_err", {7'd0, error}, 8'd0);
        @(negedge clk);
        btn_arriba = 0;
        @(negedge clk);
        m_ct = 1;
        check_all("after_listo");

        // Timeout
        guardar();
        @(negedge clk);
        n = 0;
        while (bus.esc_req === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_len", 8'(n), 8'd8);
        m_err = 1;
        check_all("timeout");
        guardar();
        chk("err_clear", {7'd0, error}, 8'd0);
        m_err = 0;
        @(negedge clk);
        chk("req_again", {7'd0, bus.esc_req}, 8'd1);
        bus.listo = 1;
        @(negedge clk);
        bus.listo = 0;
        check_all("second_write");

        // Asynchronous reset during ESPERA
        set_modo(0);
        press("min_cur", 0, 0, 0, 1);
        n = 0;
        while (cm != 37 && n < 60) begin
            press("min_set", 1, 0, 0, 0);
            n++;
        end
        chk("min_37", bus.clk_min, 8'h37);
        guardar();
        m_ct = 0;
        repeat (2) @(negedge clk);
        chk("pre_rst_req", {7'd0, bus.esc_req}, 8'd1);
        #2 reset = 1;
        #1;
        chk("rst_req", {7'd0, bus.esc_req}, 8'd0);
        chk("rst_min", bus.clk_min, 8'h00);
        chk("rst_campo", {6'd0, campo}, 8'd0);
        model_reset();
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        check_all("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/editor_hora_fecha.md
Name: editor_hora_fecha

Overview:
- Upstream user-entry stage for the RTC interface top level.
- Turns debounced push-button levels into BCD clock, timer and date values, a clock/timer select and a write request.
- Drives the top's clk_seg1/clk_min1/clk_hora1, tim_seg1/tim_min1/tim_hora1, Dia1/Mes1/Ano1, CT and WR1.
- Holds the write request until the downstream write sequence reports completion.

Parameters:
T_ESPERA, 1000, max clk cycles waiting for `listo` before aborting a write request
ANCHO_T, 10, width of the timeout counter (2^ANCHO_T must exceed T_ESPERA)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
btn_arriba  in  1  debounced level: increment field under cursor
btn_abajo  in  1  debounced level: decrement field under cursor
btn_izq  in  1  debounced level: cursor left
btn_der  in  1  debounced level: cursor right
btn_guardar  in  1  debounced level: commit current group to RTC
modo  in  2  00=clock, 01=date, 10=timer, 11=no edit
listo  in  1  write sequence finished (one-cycle pulse from write FSM)
clk_seg, clk_min, clk_hora  out  8  clock BCD values
tim_seg, tim_min, tim_hora  out  8  timer BCD values
dia, mes, ano  out  8  date BCD values
campo  out  2  cursor: 0=seg/dia, 1=min/mes, 2=hora/ano
ct  out  1  0=clock/date group, 1=timer group (registered with request)
esc_req  out  1  write request level to WR1
error  out  1  sticky timeout flag; cleared on next accepted guardar

Behaviour:
- Reset: clock=00:00:00, timer=00:00:00, dia=01, mes=01, ano=00. campo=0, ct=0, esc_req=0, error=0, FSM=EDITAR, edge registers=0.
- Edge detection:
  - Each button is registered once; action = level & ~previous.
  - Exactly one action per press, effective on the clk edge after the rising edge is seen (1-cycle latency).
- FSM states:
  - EDITAR:
    - Button actions apply.
    - guardar rising with modo!=11 → SOLICITA; ct=(modo==10); error cleared.
    - guardar with modo=11 is ignored.
  - SOLICITA: esc_req=1; timeout counter cleared; → ESPERA next cycle.
  - ESPERA:
    - esc_req stays 1; counter increments.
    - listo=1 → esc_req=0 → EDITAR.
    - counter==T_ESPERA-1 without listo → esc_req=0, error=1 → EDITAR.
    - listo and timeout in the same cycle: listo wins, no error.
  - In SOLICITA/ESPERA, all button actions are ignored and values are frozen; edges are still tracked, so held buttons do not fire on return.
- Cursor:
  - izq: campo-1, wrapping 0→2.
  - der: campo+1, wrapping 2→0.
  - izq and der in the same cycle: no move.
  - Any change of modo forces campo=0 on the next cycle; button actions in that cycle are ignored.
- Increment/decrement (BCD, tens and units nibbles):
  - arriba and abajo in the same cycle: no change.
  - seg/min: 00..59; 59+1=00, 00-1=59.
  - hora: 00..23; 23+1=00, 00-1=23.
  - mes: 01..12; 12+1=01, 01-1=12.
  - ano: 00..99; 99+1=00, 00-1=99.
  - dia: 01..max; max+1=01, 01-1=max.
  - max = 31 (01,03,05,07,08,10,12); 30 (04,06,09,11); 29 for 02 if ano%4==0, else 28.
  - Leap test: tens-digit parity and units digit. Leap when units∈{0,4,8} and tens even, or units∈{2,6} and tens odd.
  - Units 9 → 0 with tens carry; units 0 → 9 with tens borrow. Outputs never hold an invalid BCD nibble.
- Day clamp: if a mes or ano change leaves dia > new max, dia = new max in the same update cycle.
- Only the group selected by modo is editable; other groups hold.
- Mid-operation reset returns everything to reset values immediately and drops esc_req.

Test Plan:
- Reset, modo=00, campo=0, 61 arriba pulses → clk_seg goes 00..59 then 00, then 01; one abajo from 00 → 59.
- modo=00, der ×2 (campo=2), abajo from 00 → clk_hora=23; der once more → campo=0; izq and der together → campo unchanged.
- modo=01, set mes=02, ano=01, dia=31 path: dia arriba from 28 → 01. Set dia=29 with ano=04, then ano arriba to 05 → dia clamps to 28. mes=04 with dia=31 → dia=30.
- modo=10, guardar → ct=1, esc_req=1 two cycles later. listo pulse after 5 cycles → esc_req=0 next cycle, error=0. arriba during ESPERA → tim_seg unchanged.
- T_ESPERA=8, guardar with no listo → esc_req drops after 8 ESPERA cycles, error=1. Next guardar → error=0.
- Assert reset during ESPERA with clk_min=37 → esc_req=0, clk_min=00, campo=0 without waiting for clk.
